// File: rtl/lvds_ber_pkg.sv
// Shared definitions for the LVDS BER link: checker FSM encoding, PRBS tap
// masks per polynomial order and the counter widths used by the display path.
package lvds_ber_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_t;

  localparam int RECV_W = 58;
  localparam int ERR_W  = 64;
  localparam int LOSS_W = 16;

  // Bit k set means state bit k (age k+1 in the received history) feeds back.
  function automatic logic [31:0] tap_mask(input int len);
    logic [31:0] m;
    case (len)
      32'd7:   m = 32'h0000_0060;
      32'd15:  m = 32'h0000_6000;
      32'd31:  m = 32'h4800_0000;
      default: m = 32'h0000_0060;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/prbs_step2.sv
// Combinational two-step Fibonacci LFSR: next state after two shifts and the
// two output bits, earlier bit in bits[1]. Shared with the transmit generator.
module prbs_step2
  import lvds_ber_pkg::*;
#(
  parameter int                LEN  = 7,
  parameter logic [LEN-1:0]    TAPS = LEN'(tap_mask(LEN))
) (
  input  logic [LEN-1:0] state,
  output logic [LEN-1:0] next_state,
  output logic [1:0]     bits
);

  logic           b1;
  logic           b0;
  logic [LEN-1:0] mid;

  // State bit 0 holds the newest bit, so each step shifts left and appends.
  always_comb begin
    b1         = ^(state & TAPS);
    mid        = {state[LEN-2:0], b1};
    b0         = ^(mid & TAPS);
    next_state = {mid[LEN-2:0], b0};
    bits       = {b1, b0};
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// Receive-side PRBS checker: self-synchronises an LFSR to the 2-bit/cycle
// stream, then counts checked bits, bit errors and lock losses.
module prbs_rx_checker
  import lvds_ber_pkg::*;
#(
  parameter int LFSR_LEN   = 7,
  parameter int VERIFY_CYC = 64,
  parameter int LOSS_WIN   = 256,
  parameter int LOSS_THR   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        din,
  output logic              locked,
  output logic [RECV_W-1:0] recv_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int HUNT_LOADS = (LFSR_LEN + 1) / 2;
  localparam int HUNT_W     = $clog2(HUNT_LOADS + 1);
  localparam int VER_W      = $clog2(VERIFY_CYC + 1);
  localparam int WIN_W      = $clog2(LOSS_WIN);
  localparam int WERR_W     = $clog2(LOSS_THR + 3);
  localparam logic [31:0]         TAP_ALL = tap_mask(LFSR_LEN);
  localparam logic [LFSR_LEN-1:0] TAPS    = TAP_ALL[LFSR_LEN-1:0];

  ber_state_t          state, state_nx;
  logic [LFSR_LEN-1:0] lfsr, lfsr_nx, lfsr_run;
  logic [1:0]          din_q, exp_bits, mism;
  logic                din_vld, step;
  logic [HUNT_W-1:0]   hunt_cnt, hunt_nx;
  logic [VER_W-1:0]    ver_cnt, ver_nx;
  logic [WIN_W-1:0]    win_cnt, win_nx;
  logic [WERR_W-1:0]   win_err, werr_nx, win_tot;
  logic                recv_inc, loss_inc;
  logic [1:0]          err_add;
  logic [RECV_W:0]     recv_sum;
  logic [ERR_W:0]      err_sum;
  logic [LOSS_W:0]     loss_sum;

  prbs_step2 #(.LEN(LFSR_LEN), .TAPS(TAPS)) u_step (
    .state      (lfsr),
    .next_state (lfsr_run),
    .bits       (exp_bits)
  );

  // din_q is only consumed once a real sample has been captured after reset.
  assign step    = en & din_vld;
  assign mism    = popcount2(din_q ^ exp_bits);
  assign win_tot = win_err + WERR_W'(mism);

  // Next-state logic for the hunt / verify / locked sequence and window tracking.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    hunt_nx  = hunt_cnt;
    ver_nx   = ver_cnt;
    win_nx   = win_cnt;
    werr_nx  = win_err;
    recv_inc = 1'b0;
    loss_inc = 1'b0;
    err_add  = 2'b00;
    case (state)
      ST_HUNT: begin
        lfsr_nx = {lfsr[LFSR_LEN-3:0], din_q};
        if (hunt_cnt == HUNT_W'(HUNT_LOADS - 1)) begin
          state_nx = ST_VERIFY;
          hunt_nx  = {HUNT_W{1'b0}};
          ver_nx   = {VER_W{1'b0}};
        end else begin
          hunt_nx = hunt_cnt + HUNT_W'(1);
        end
      end
      ST_VERIFY: begin
        lfsr_nx = lfsr_run;
        // An all-zero seed would predict a stuck-low line forever.
        if ((mism != 2'b00) || (lfsr == {LFSR_LEN{1'b0}})) begin
          state_nx = ST_HUNT;
          hunt_nx  = {HUNT_W{1'b0}};
        end else if (ver_cnt == VER_W'(VERIFY_CYC - 1)) begin
          state_nx = ST_LOCKED;
          win_nx   = {WIN_W{1'b0}};
          werr_nx  = {WERR_W{1'b0}};
        end else begin
          ver_nx = ver_cnt + VER_W'(1);
        end
      end
      ST_LOCKED: begin
        lfsr_nx  = lfsr_run;
        recv_inc = 1'b1;
        err_add  = mism;
        win_nx   = win_cnt + WIN_W'(1);
        if (win_tot >= WERR_W'(LOSS_THR)) begin
          state_nx = ST_HUNT;
          hunt_nx  = {HUNT_W{1'b0}};
          loss_inc = 1'b1;
        end else if (win_cnt == WIN_W'(LOSS_WIN - 1)) begin
          werr_nx = {WERR_W{1'b0}};
        end else begin
          werr_nx = win_tot;
        end
      end
      default: begin
        state_nx = ST_HUNT;
        hunt_nx  = {HUNT_W{1'b0}};
      end
    endcase
  end

  always_comb begin
    recv_sum = {1'b0, recv_cnt} + {{(RECV_W-1){1'b0}}, recv_inc, 1'b0};
    err_sum  = {1'b0, err_cnt} + {{(ERR_W-1){1'b0}}, err_add};
    loss_sum = {1'b0, loss_cnt} + {{LOSS_W{1'b0}}, loss_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q    <= 2'b00;
      din_vld  <= 1'b0;
      state    <= ST_HUNT;
      lfsr     <= {LFSR_LEN{1'b0}};
      hunt_cnt <= {HUNT_W{1'b0}};
      ver_cnt  <= {VER_W{1'b0}};
      win_cnt  <= {WIN_W{1'b0}};
      win_err  <= {WERR_W{1'b0}};
      locked   <= 1'b0;
    end else begin
      if (en) begin
        din_q   <= din;
        din_vld <= 1'b1;
      end
      if (step) begin
        state    <= state_nx;
        lfsr     <= lfsr_nx;
        hunt_cnt <= hunt_nx;
        ver_cnt  <= ver_nx;
        win_cnt  <= win_nx;
        win_err  <= werr_nx;
        locked   <= (state_nx == ST_LOCKED);
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment and ignores en.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      recv_cnt <= {RECV_W{1'b0}};
      err_cnt  <= {ERR_W{1'b0}};
      loss_cnt <= {LOSS_W{1'b0}};
    end else if (step) begin
      recv_cnt <= recv_sum[RECV_W] ? {RECV_W{1'b1}} : recv_sum[RECV_W-1:0];
      err_cnt  <= err_sum[ERR_W]   ? {ERR_W{1'b1}}  : err_sum[ERR_W-1:0];
      loss_cnt <= loss_sum[LOSS_W] ? {LOSS_W{1'b1}} : loss_sum[LOSS_W-1:0];
    end
  end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Directed bench for prbs_rx_checker: PRBS7 source model, a vector table for
// locked-mode error/clear behaviour and hand-written lock/loss/reset sequences.
module tb_prbs_rx_checker;
  import lvds_ber_pkg::*;

  logic              clk = 1'b0;
  logic              rst, en, clr;
  logic [1:0]        din;
  logic              locked;
  logic [RECV_W-1:0] recv_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [LOSS_W-1:0] loss_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] gen;

  typedef struct {
    int                ncyc;
    logic              en;
    int                flip_at;
    logic [1:0]        flip;
    int                clr_at;
    logic              exp_locked;
    logic [RECV_W-1:0] exp_recv;
    logic [ERR_W-1:0]  exp_err;
    logic [LOSS_W-1:0] exp_loss;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  prbs_rx_checker #(
    .LFSR_LEN   (7),
    .VERIFY_CYC (64),
    .LOSS_WIN   (256),
    .LOSS_THR   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .din      (din),
    .locked   (locked),
    .recv_cnt (recv_cnt),
    .err_cnt  (err_cnt),
    .loss_cnt (loss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic [RECV_W-1:0] r,
                           input logic [ERR_W-1:0] e, input logic [LOSS_W-1:0] s);
    check({tag, ".locked"}, 64'(locked), 64'(l));
    check({tag, ".recv"}, 64'(recv_cnt), 64'(r));
    check({tag, ".err"}, err_cnt, e);
    check({tag, ".loss"}, 64'(loss_cnt), 64'(s));
  endtask

  task automatic check_lock_time(input string name, input int n);
    n_cmp++;
    if (n < 68 || n > 70) begin
      n_bad++;
      $display("FAIL %s: locked after %0d cycles, expected 68..70", name, n);
    end
  endtask

  // PRBS7 source, b[n] = b[n-7] ^ b[n-6]; gen[0] is the newest bit.
  task automatic next_pair(output logic [1:0] p);
    logic b1, b0;
    b1  = gen[6] ^ gen[5];
    gen = {gen[5:0], b1};
    b0  = gen[6] ^ gen[5];
    gen = {gen[5:0], b0};
    p   = {b1, b0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic e, input logic [1:0] flip, input logic c);
    logic [1:0] p;
    en  = e;
    clr = c;
    if (e) begin
      next_pair(p);
      din = p ^ flip;
    end
    tick();
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      cycle(1'b1, 2'b00, 1'b0);
      n++;
    end
  endtask

  initial begin
    int   n;
    logic seen;
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    din = 2'b00;
    gen = 7'h7F;

    //                ncyc en   flip_at flip   clr_at lock  recv      err       loss
    tbl[0] = '{1,  1'b1, -1, 2'b00,  0, 1'b1, 58'd0,  64'd0, 16'd0};
    tbl[1] = '{10, 1'b1, -1, 2'b00, -1, 1'b1, 58'd20, 64'd0, 16'd0};
    tbl[2] = '{5,  1'b1,  0, 2'b01, -1, 1'b1, 58'd30, 64'd1, 16'd0};
    tbl[3] = '{5,  1'b1,  0, 2'b10, -1, 1'b1, 58'd40, 64'd2, 16'd0};
    tbl[4] = '{4,  1'b1,  0, 2'b11, -1, 1'b1, 58'd48, 64'd4, 16'd0};
    tbl[5] = '{2,  1'b1,  0, 2'b01,  1, 1'b1, 58'd0,  64'd0, 16'd0};
    tbl[6] = '{3,  1'b1, -1, 2'b00, -1, 1'b1, 58'd6,  64'd0, 16'd0};
    tbl[7] = '{1,  1'b0, -1, 2'b00,  0, 1'b1, 58'd0,  64'd0, 16'd0};
    tbl[8] = '{4,  1'b1, -1, 2'b00, -1, 1'b1, 58'd8,  64'd0, 16'd0};

    tick();
    tick();
    check_all("reset", 1'b0, 58'd0, 64'd0, 16'd0);
    rst = 1'b0;

    wait_lock(n);
    check_lock_time("first_lock", n);
    check_all("at_lock", 1'b1, 58'd0, 64'd0, 16'd0);
    repeat (1000) cycle(1'b1, 2'b00, 1'b0);
    check_all("clean1000", 1'b1, 58'd2000, 64'd0, 16'd0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].ncyc; k++)
        cycle(tbl[i].en, (k == tbl[i].flip_at) ? tbl[i].flip : 2'b00, k == tbl[i].clr_at);
      check_all($sformatf("row%0d", i), tbl[i].exp_locked, tbl[i].exp_recv,
                tbl[i].exp_err, tbl[i].exp_loss);
    end

    force dut.err_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    force dut.recv_cnt = 58'h3FF_FFFF_FFFF_FFFE;
    #1;
    release dut.err_cnt;
    release dut.recv_cnt;
    cycle(1'b1, 2'b11, 1'b0);
    check("sat_recv", 64'(recv_cnt), 64'(58'h3FF_FFFF_FFFF_FFFF));
    check("sat_err_pre", err_cnt, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle(1'b1, 2'b00, 1'b0);
    check("sat_err", err_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b00, 1'b0);
    check("sat_err_hold", err_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sat_recv_hold", 64'(recv_cnt), 64'(58'h3FF_FFFF_FFFF_FFFF));

    cycle(1'b1, 2'b00, 1'b1);
    repeat (5) cycle(1'b1, 2'b00, 1'b0);
    check_all("pre_pause", 1'b1, 58'd10, 64'd0, 16'd0);
    repeat (50) cycle(1'b0, 2'b00, 1'b0);
    check_all("paused", 1'b1, 58'd10, 64'd0, 16'd0);
    repeat (20) cycle(1'b1, 2'b00, 1'b0);
    check_all("resumed", 1'b1, 58'd50, 64'd0, 16'd0);

    rst = 1'b1;
    cycle(1'b1, 2'b00, 1'b0);
    check_all("mid_rst", 1'b0, 58'd0, 64'd0, 16'd0);
    rst = 1'b0;

    wait_lock(n);
    check_lock_time("lock_after_rst", n);
    for (int j = 1; j <= 316; j++) begin
      cycle(1'b1, ((j <= 15) || (j >= 300 && j <= 315)) ? 2'b01 : 2'b00, 1'b0);
      if (j == 256) check_all("err15_kept", 1'b1, 58'd512, 64'd15, 16'd0);
      if (j == 315) check("err15_win1", 64'(locked), 64'd1);
      if (j == 316) check_all("err16_loss", 1'b0, 58'd632, 64'd31, 16'd1);
    end
    wait_lock(n);
    check_lock_time("relock", n);
    check("relock_loss", 64'(loss_cnt), 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    en   = 1'b1;
    din  = 2'b00;
    seen = 1'b0;
    repeat (10000) begin
      tick();
      seen = seen | locked;
    end
    check("zero_never_locked", 64'(seen), 64'd0);
    check_all("zero_line", 1'b0, 58'd0, 64'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
